mmio_initiator: RTL and testbench

- MMIO bus initiator: the requesting end of the `mmio_read` / `mmio_write` / `mmio_done` handshake that the MMIO peripherals (UART, GPIO, timers) respond to.
- Sits between the CPU memory stage and the shared MMIO bus.
- Accepts one request at a time, holds bus signals stable until the responder pulses `mmio_done`, then returns read data or an error.
- Inserts a mandatory idle gap so responders with edge-detected multi-cycle reads see a clean deassertion between accesses.

---
 rtl/mmio_pkg.sv | 17 +
 rtl/mmio_initiator.sv | 163 ++++++++++++++++
 tb/tb_mmio_initiator.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bus initiator: FSM state encoding,
// the MMIO window base and default timeout / idle-gap constants.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // Upper half-word of the MMIO address window.
    localparam logic [15:0] MMIO_BASE_HI = 16'hFFFF;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEF_GAP_CYCLES     = 1;

endpackage

// File: rtl/mmio_initiator.sv
// MMIO bus initiator: takes one CPU request at a time, drives the
// mmio_read/mmio_write strobes until a responder pulses mmio_done,
// aborts on unmapped addresses or timeout, then forces an idle gap.
//
// Ports:
//   sys_clk, rst            clock, async active-high reset
//   cpu_req_*               CPU request (valid/ready, we, addr, wdata)
//   cpu_resp_*              one-cycle response pulse, rdata, err
//   mmio_read/write/addr/write_data  bus outputs, held for the access
//   mmio_work/done/read_data         bus inputs from the responders
//   err_clear/err_sticky/err_addr    only with MMIO_ERR_CAPTURE_EN
//
// Build option: define MMIO_ERR_CAPTURE_EN to add sticky error capture.
module mmio_initiator
    import mmio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_req_we,
    input  logic [31:0] cpu_req_addr,
    input  logic [31:0] cpu_req_wdata,
    output logic        cpu_resp_valid,
    output logic [31:0] cpu_resp_rdata,
    output logic        cpu_resp_err,
    output logic        mmio_read,
    output logic        mmio_write,
    output logic [31:0] mmio_addr,
    output logic [31:0] mmio_write_data,
    input  logic        mmio_work,
    input  logic        mmio_done,
    input  logic [31:0] mmio_read_data
`ifdef MMIO_ERR_CAPTURE_EN
    ,
    input  logic        err_clear,
    output logic        err_sticky,
    output logic [31:0] err_addr
`endif
);

    localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] LP_GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t      r_state;
    logic        r_rd;
    logic        r_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_rdata;
    logic [15:0] r_tmo_cnt;
    logic [15:0] r_gap_cnt;
    logic        r_first;

    logic        w_unmapped;
    logic        w_timeout;

    // Address claim is only meaningful on the first bus cycle; a
    // responder dropping mmio_work later must not abort the access.
    assign w_unmapped = r_first & ~mmio_work;
    assign w_timeout  = (r_tmo_cnt == LP_TMO_LAST);

    assign cpu_req_ready   = (r_state == ST_IDLE);
    assign cpu_resp_valid  = r_resp_valid;
    assign cpu_resp_err    = r_resp_err;
    assign cpu_resp_rdata  = r_rdata;
    assign mmio_read       = r_rd;
    assign mmio_write      = r_wr;
    assign mmio_addr       = r_addr;
    assign mmio_write_data = r_wdata;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= 32'h0;
            r_tmo_cnt    <= 16'h0;
            r_gap_cnt    <= 16'h0;
            r_first      <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (cpu_req_valid) begin
                        r_addr    <= cpu_req_addr;
                        r_wdata   <= cpu_req_wdata;
                        r_rd      <= ~cpu_req_we;
                        r_wr      <= cpu_req_we;
                        r_tmo_cnt <= 16'h0;
                        r_first   <= 1'b1;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_first <= 1'b0;
                    if (mmio_done) begin
                        r_rdata      <= r_wr ? 32'h0 : mmio_read_data;
                        r_resp_valid <= 1'b1;
                        r_rd         <= 1'b0;
                        r_wr         <= 1'b0;
                        r_gap_cnt    <= 16'h0;
                        r_state      <= ST_GAP;
                    end else if (w_unmapped || w_timeout) begin
                        r_rdata      <= 32'h0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_rd         <= 1'b0;
                        r_wr         <= 1'b0;
                        r_gap_cnt    <= 16'h0;
                        r_state      <= ST_GAP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'h1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == LP_GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'h1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MMIO_ERR_CAPTURE_EN
    logic        r_err_sticky;
    logic [31:0] r_err_addr;
    logic        w_err;

    assign w_err = (r_state == ST_ACCESS) & ~mmio_done
                 & (w_unmapped | w_timeout);

    assign err_sticky = r_err_sticky;
    assign err_addr   = r_err_addr;

    // First error after a clear is kept; clear beats a same-cycle error.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_err_addr   <= 32'h0;
        end else if (err_clear) begin
            r_err_sticky <= 1'b0;
        end else if (w_err && !r_err_sticky) begin
            r_err_sticky <= 1'b1;
            r_err_addr   <= r_addr;
        end
    end
`endif

endmodule

// File: tb/tb_mmio_initiator.sv
// Directed bench for mmio_initiator with an inline MMIO responder
// (configurable wait cycles, claimed address window, read data).
module tb_mmio_initiator;
    import mmio_pkg::*;

    localparam int unsigned TMO = 16;
    localparam int unsigned GAP = 1;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_req_we;
    logic [31:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        cpu_resp_err;
    logic        mmio_read;
    logic        mmio_write;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_write_data;
    logic        mmio_work;
    logic        mmio_done;
    logic [31:0] mmio_read_data;

    int compared = 0;
    int mismatched = 0;

    always #5 sys_clk = ~sys_clk;

    mmio_initiator #(
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAP)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_we     (cpu_req_we),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .cpu_resp_err   (cpu_resp_err),
        .mmio_read      (mmio_read),
        .mmio_write     (mmio_write),
        .mmio_addr      (mmio_addr),
        .mmio_write_data(mmio_write_data),
        .mmio_work      (mmio_work),
        .mmio_done      (mmio_done),
        .mmio_read_data (mmio_read_data)
    );

    // Responder model: claims the MMIO window, done after rsp_wait
    // extra strobe cycles.
    int          rsp_wait = 0;
    int          rsp_cnt;
    logic [31:0] rsp_data = 32'h0;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        w_strobe;

    assign rsp_lo    = {MMIO_BASE_HI, 16'h0000};
    assign rsp_hi    = {MMIO_BASE_HI, 16'hFFFF};
    assign w_strobe  = mmio_read | mmio_write;
    assign mmio_work = (mmio_addr >= rsp_lo) && (mmio_addr <= rsp_hi);
    assign mmio_done = w_strobe && mmio_work && (rsp_cnt == rsp_wait);
    assign mmio_read_data = mmio_done ? rsp_data : 32'h0;

    always @(posedge sys_clk or posedge rst) begin
        if (rst)           rsp_cnt <= 0;
        else if (w_strobe) rsp_cnt <= rsp_cnt + 1;
        else               rsp_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to its response (bounded).
    task automatic run_txn(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata,
                           output logic rdy, output int n_rd,
                           output int n_wr, output int lat,
                           output logic [31:0] rdata, output logic err,
                           output logic stable, output logic got);
        @(negedge sys_clk);
        rdy = cpu_req_ready;
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wdata;
        @(negedge sys_clk);
        cpu_req_valid = 1'b0;
        n_rd = 0; n_wr = 0; lat = 0;
        rdata = 32'hx; err = 1'bx;
        stable = 1'b1; got = 1'b0;
        for (int c = 1; c <= 100 && !got; c++) begin
            if (mmio_read)  n_rd++;
            if (mmio_write) n_wr++;
            if (mmio_read && mmio_write) stable = 1'b0;
            if (w_strobe && (mmio_addr !== addr ||
                             mmio_write_data !== wdata))
                stable = 1'b0;
            if (cpu_resp_valid) begin
                got = 1'b1; lat = c;
                rdata = cpu_resp_rdata; err = cpu_resp_err;
            end else begin
                @(negedge sys_clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic        t_rdy, t_err, t_stable, t_got;
    int          t_rd, t_wr, t_lat;
    logic [31:0] t_rdata;

    initial begin
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = 32'h0;
        cpu_req_wdata = 32'h0;

        // Reset state
        repeat (2) @(negedge sys_clk);
        check("rst_ready", 32'(cpu_req_ready), 32'd1);
        check("rst_rd", 32'(mmio_read), 32'd0);
        check("rst_wr", 32'(mmio_write), 32'd0);
        check("rst_rv", 32'(cpu_resp_valid), 32'd0);
        check("rst_err", 32'(cpu_resp_err), 32'd0);
        check("rst_addr", mmio_addr, 32'h0);
        check("rst_wdata", mmio_write_data, 32'h0);
        check("rst_rdata", cpu_resp_rdata, 32'h0);
        rst = 1'b0;

        // Single zero-wait write
        rsp_wait = 0;
        run_txn(1'b1, 32'hFFFF0134, 32'h41, t_rdy, t_rd, t_wr,
                t_lat, t_rdata, t_err, t_stable, t_got);
        check("wr_ready", 32'(t_rdy), 32'd1);
        check("wr_got", 32'(t_got), 32'd1);
        check("wr_wcyc", 32'(t_wr), 32'd1);
        check("wr_rcyc", 32'(t_rd), 32'd0);
        check("wr_lat", 32'(t_lat), 32'd2);
        check("wr_stable", 32'(t_stable), 32'd1);
        check("wr_err", 32'(t_err), 32'd0);
        check("wr_rdata", t_rdata, 32'h0);
        @(negedge sys_clk);
        check("wr_pulse", 32'(cpu_resp_valid), 32'd0);

        // Read with one responder wait cycle
        rsp_wait = 1;
        rsp_data = 32'h5A;
        run_txn(1'b0, 32'hFFFF0124, 32'h0, t_rdy, t_rd, t_wr,
                t_lat, t_rdata, t_err, t_stable, t_got);
        check("rd_got", 32'(t_got), 32'd1);
        check("rd_rcyc", 32'(t_rd), 32'd2);
        check("rd_wcyc", 32'(t_wr), 32'd0);
        check("rd_lat", 32'(t_lat), 32'd3);
        check("rd_stable", 32'(t_stable), 32'd1);
        check("rd_err", 32'(t_err), 32'd0);
        check("rd_rdata", t_rdata, 32'h0000005A);

        // Unmapped address
        rsp_wait = 0;
        run_txn(1'b0, 32'h10000000, 32'h0, t_rdy, t_rd, t_wr,
                t_lat, t_rdata, t_err, t_stable, t_got);
        check("um_got", 32'(t_got), 32'd1);
        check("um_rcyc", 32'(t_rd), 32'd1);
        check("um_lat", 32'(t_lat), 32'd2);
        check("um_err", 32'(t_err), 32'd1);
        check("um_rdata", t_rdata, 32'h0);

        // Timeout: claimed but never done
        rsp_wait = 100000;
        rsp_data = 32'hDEAD;
        run_txn(1'b0, 32'hFFFF0200, 32'h0, t_rdy, t_rd, t_wr,
                t_lat, t_rdata, t_err, t_stable, t_got);
        check("to_got", 32'(t_got), 32'd1);
        check("to_rcyc", 32'(t_rd), 32'd16);
        check("to_lat", 32'(t_lat), 32'd17);
        check("to_err", 32'(t_err), 32'd1);
        check("to_rdata", t_rdata, 32'h0);

        // Back-to-back reads with cpu_req_valid held
        rsp_wait = 0;
        rsp_data = 32'h11;
        @(negedge sys_clk);
        check("bb_ready0", 32'(cpu_req_ready), 32'd1);
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = 32'hFFFF0100;
        cpu_req_wdata = 32'h0;
        @(negedge sys_clk);
        check("bb_rd1", 32'(mmio_read), 32'd1);
        check("bb_addr1", mmio_addr, 32'hFFFF0100);
        cpu_req_addr = 32'hFFFF0104;
        @(negedge sys_clk);
        check("bb_rv1", 32'(cpu_resp_valid), 32'd1);
        check("bb_data1", cpu_resp_rdata, 32'h11);
        check("bb_gap_rdy", 32'(cpu_req_ready), 32'd0);
        check("bb_gap_stb", 32'(w_strobe), 32'd0);
        rsp_data = 32'h22;
        @(negedge sys_clk);
        check("bb_idle_rdy", 32'(cpu_req_ready), 32'd1);
        check("bb_idle_stb", 32'(w_strobe), 32'd0);
        @(negedge sys_clk);
        cpu_req_valid = 1'b0;
        check("bb_rd2", 32'(mmio_read), 32'd1);
        check("bb_addr2", mmio_addr, 32'hFFFF0104);
        @(negedge sys_clk);
        check("bb_rv2", 32'(cpu_resp_valid), 32'd1);
        check("bb_data2", cpu_resp_rdata, 32'h22);

        // Reset during the third ACCESS cycle
        rsp_wait = 100000;
        @(negedge sys_clk);
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = 32'hFFFF0300;
        @(negedge sys_clk);
        cpu_req_valid = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("mr_rd_before", 32'(mmio_read), 32'd1);
        rst = 1'b1;
        #1;
        check("mr_rd_async", 32'(mmio_read), 32'd0);
        check("mr_addr_async", mmio_addr, 32'h0);
        @(negedge sys_clk);
        check("mr_rv_rst", 32'(cpu_resp_valid), 32'd0);
        rst = 1'b0;
        rsp_wait = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check("mr_rv_after", 32'(cpu_resp_valid), 32'd0);
            check("mr_ready", 32'(cpu_req_ready), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
